// File: rtl/rob_commit_ctrl_if.sv
// Bundle of the decoder, CDB, query and regFile-side signals of rob_commit_ctrl.
// The master drives the requests, and the slave (the ROB) drives the responses.
interface rob_commit_ctrl_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [REG_W-1:0]  rf_occ_reg;
  logic [TAG_W-1:0]  rf_occ_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [TAG_W-1:0]  query_tag1;
  logic [TAG_W-1:0]  query_tag2;
  logic              query_rdy1;
  logic              query_rdy2;
  logic [DATA_W-1:0] query_val1;
  logic [DATA_W-1:0] query_val2;
  logic [REG_W-1:0]  rf_wr_reg;
  logic [TAG_W-1:0]  rf_wr_tag;
  logic [DATA_W-1:0] rf_wr_value;
  logic              rf_clear;
  logic [TAG_W-1:0]  rob_count;

  modport master (
    output flush, alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, query_tag1, query_tag2,
    input  alloc_ready, alloc_tag, rf_occ_reg, rf_occ_tag, query_rdy1, query_rdy2,
           query_val1, query_val2, rf_wr_reg, rf_wr_tag, rf_wr_value, rf_clear, rob_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_value, query_tag1, query_tag2,
    output alloc_ready, alloc_tag, rf_occ_reg, rf_occ_tag, query_rdy1, query_rdy2,
           query_val1, query_val2, rf_wr_reg, rf_wr_tag, rf_wr_value, rf_clear, rob_count
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order-retire reorder buffer. It allocates tags, captures CDB results and drives the regFile ports.
// Optional macro ROB_BYPASS_EN: operand queries also see the CDB result of the current cycle.
module rob_commit_ctrl #(
  parameter int ROB_DEPTH = 15,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  rob_commit_ctrl_if.slave  bus
);
  localparam int              NENT    = 1 << TAG_W;
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(ROB_DEPTH);
  localparam logic [TAG_W-1:0] ONE_T   = TAG_W'(1);

  // Entry 0 and any entry above ROB_DEPTH are never allocated. These entries therefore stay not-busy.
  logic              busy_q [NENT];
  logic              done_q [NENT];
  logic [REG_W-1:0]  rd_q   [NENT];
  logic [DATA_W-1:0] val_q  [NENT];
  logic              busy_d [NENT];
  logic              done_d [NENT];
  logic [REG_W-1:0]  rd_d   [NENT];
  logic [DATA_W-1:0] val_d  [NENT];

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [TAG_W-1:0]  wr_tag_q, wr_tag_d;
  logic [DATA_W-1:0] wr_val_q, wr_val_d;
  logic              clear_q, clear_d;

  logic alloc_ready, alloc_fire, commit_fire, cdb_hit;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == DEPTH_T) ? ONE_T : p + ONE_T;
  endfunction

  // The ready signal depends only on the registered count, so a retire cannot open issue in the same cycle.
  assign alloc_ready = (count_q < DEPTH_T) && !bus.flush;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign commit_fire = busy_q[head_q] && done_q[head_q];
  assign cdb_hit     = bus.cdb_valid && busy_q[bus.cdb_tag] && !done_q[bus.cdb_tag];

  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    rd_d     = rd_q;
    val_d    = val_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_reg_d = '0;
    wr_tag_d = '0;
    wr_val_d = '0;
    clear_d  = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < NENT; i++) begin
        busy_d[i] = 1'b0;
        done_d[i] = 1'b0;
        rd_d[i]   = '0;
        val_d[i]  = '0;
      end
      head_d  = ONE_T;
      tail_d  = ONE_T;
      count_d = '0;
      clear_d = 1'b1;
    end else begin
      if (commit_fire) begin
        wr_reg_d       = rd_q[head_q];
        wr_tag_d       = head_q;
        wr_val_d       = val_q[head_q];
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        rd_d[head_q]   = '0;
        val_d[head_q]  = '0;
        head_d         = ptr_inc(head_q);
      end
      if (cdb_hit) begin
        done_d[bus.cdb_tag] = 1'b1;
        val_d[bus.cdb_tag]  = bus.cdb_value;
      end
      // The alloc write comes last, so a fresh entry overrides any other update to the tail slot.
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = bus.alloc_rd;
        val_d[tail_q]  = '0;
        tail_d         = ptr_inc(tail_q);
      end
      count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
      end
      head_q   <= ONE_T;
      tail_q   <= ONE_T;
      count_q  <= '0;
      wr_reg_q <= '0;
      wr_tag_q <= '0;
      wr_val_q <= '0;
      clear_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_reg_q <= wr_reg_d;
      wr_tag_q <= wr_tag_d;
      wr_val_q <= wr_val_d;
      clear_q  <= clear_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
    assign tag = (gi == 0) ? bus.query_tag1 : bus.query_tag2;
    always_comb begin
      rdy = busy_q[tag] && done_q[tag];
      val = rdy ? val_q[tag] : '0;
`ifdef ROB_BYPASS_EN
      if (bus.cdb_valid && (bus.cdb_tag == tag) && busy_q[tag] && !done_q[tag]) begin
        rdy = 1'b1;
        val = bus.cdb_value;
      end
`endif
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail_q;
  assign bus.rf_occ_reg  = alloc_fire ? bus.alloc_rd : '0;
  assign bus.rf_occ_tag  = tail_q;
  assign bus.query_rdy1  = g_query[0].rdy;
  assign bus.query_val1  = g_query[0].val;
  assign bus.query_rdy2  = g_query[1].rdy;
  assign bus.query_val2  = g_query[1].val;
  assign bus.rf_wr_reg   = wr_reg_q;
  assign bus.rf_wr_tag   = wr_tag_q;
  assign bus.rf_wr_value = wr_val_q;
  assign bus.rf_clear    = clear_q;
  assign bus.rob_count   = count_q;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl. It covers reset, the commit path, ordering, fill/wrap, flush and query.
module tb_rob_commit_ctrl;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  rob_commit_ctrl_if #(.TAG_W(4), .DATA_W(32), .REG_W(5)) bus ();

  rob_commit_ctrl #(.ROB_DEPTH(15), .TAG_W(4), .DATA_W(32), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = rd;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = value;
  endtask

  initial begin
    rst             = 1'b0;
    bus.flush       = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.query_tag1  = '0;
    bus.query_tag2  = '0;
    #12;
    chk("rst_count", 32'(bus.rob_count), 0);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 1);
    chk("rst_ready", 32'(bus.alloc_ready), 1);
    chk("rst_wr_reg", 32'(bus.rf_wr_reg), 0);
    chk("rst_clear", 32'(bus.rf_clear), 0);
    chk("rst_qrdy", 32'(bus.query_rdy1), 0);
    rst = 1'b1;
    cyc();

    // Single commit path: the result is captured at edge N and written to the regFile after edge N+1.
    alloc(5'd3);
    #1;
    chk("occ_reg", 32'(bus.rf_occ_reg), 3);
    chk("occ_tag", 32'(bus.rf_occ_tag), 1);
    cyc();
    bus.alloc_valid = 1'b0;
    cdb(4'd1, 32'hDEAD);
    #1;
    chk("t2_count", 32'(bus.rob_count), 1);
    chk("t2_alloc_tag", 32'(bus.alloc_tag), 2);
    chk("t2_occ_idle", 32'(bus.rf_occ_reg), 0);
    cyc();
    cdb(4'd1, 32'hBEEF);
    bus.query_tag1 = 4'd1;
    #1;
    chk("t2_no_early", 32'(bus.rf_wr_reg), 0);
    chk("t2_q_rdy", 32'(bus.query_rdy1), 1);
    chk("t2_q_val", bus.query_val1, 32'hDEAD);
    cyc();
    bus.cdb_valid = 1'b0;
    #1;
    chk("t2_wr_reg", 32'(bus.rf_wr_reg), 3);
    chk("t2_wr_tag", 32'(bus.rf_wr_tag), 1);
    chk("t2_wr_val", bus.rf_wr_value, 32'hDEAD);
    chk("t2_count0", 32'(bus.rob_count), 0);
    chk("t2_q_cleared", 32'(bus.query_rdy1), 0);
    cyc();
    chk("t2_wr_pulse", 32'(bus.rf_wr_reg), 0);
    chk("t2_wr_val0", bus.rf_wr_value, 0);

    // Flush with 4 entries in flight (tags 2..5), while an alloc and a CDB are offered in the same cycle.
    for (int i = 1; i <= 4; i++) begin
      alloc(5'(i));
      cyc();
    end
    bus.alloc_valid = 1'b0;
    #1;
    chk("t5_count4", 32'(bus.rob_count), 4);
    chk("t5_tag6", 32'(bus.alloc_tag), 6);
    bus.flush = 1'b1;
    alloc(5'd8);
    cdb(4'd3, 32'h77);
    #1;
    chk("t5_ready_flush", 32'(bus.alloc_ready), 0);
    chk("t5_occ_flush", 32'(bus.rf_occ_reg), 0);
    cyc();
    bus.flush       = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.query_tag1  = 4'd3;
    #1;
    chk("t5_clear", 32'(bus.rf_clear), 1);
    chk("t5_count0", 32'(bus.rob_count), 0);
    chk("t5_alloc_tag", 32'(bus.alloc_tag), 1);
    chk("t5_wr_reg", 32'(bus.rf_wr_reg), 0);
    chk("t5_no_capture", 32'(bus.query_rdy1), 0);
    cyc();
    chk("t5_clear_pulse", 32'(bus.rf_clear), 0);

    // Out-of-order completion (results for tags 3, 2, 1) must still retire in order (tags 1, 2, 3).
    alloc(5'd5);
    cyc();
    alloc(5'd6);
    cyc();
    alloc(5'd7);
    cyc();
    bus.alloc_valid = 1'b0;
    cdb(4'd3, 32'h33);
    cyc();
    cdb(4'd2, 32'h22);
    cyc();
    chk("t4_hold_a", 32'(bus.rf_wr_reg), 0);
    cdb(4'd1, 32'h11);
    cyc();
    chk("t4_hold_b", 32'(bus.rf_wr_reg), 0);
    bus.cdb_valid = 1'b0;
    cyc();
    chk("t4_c1_tag", 32'(bus.rf_wr_tag), 1);
    chk("t4_c1_reg", 32'(bus.rf_wr_reg), 5);
    chk("t4_c1_val", bus.rf_wr_value, 32'h11);
    cyc();
    chk("t4_c2_tag", 32'(bus.rf_wr_tag), 2);
    chk("t4_c2_val", bus.rf_wr_value, 32'h22);
    cyc();
    chk("t4_c3_tag", 32'(bus.rf_wr_tag), 3);
    chk("t4_c3_reg", 32'(bus.rf_wr_reg), 7);
    cyc();
    chk("t4_idle", 32'(bus.rf_wr_reg), 0);
    chk("t4_count0", 32'(bus.rob_count), 0);

    // Asynchronous reset asserted in the middle of a cycle, with 5 entries occupied.
    for (int i = 1; i <= 5; i++) begin
      alloc(5'(i));
      cyc();
    end
    bus.alloc_valid = 1'b0;
    #1;
    chk("t1_count5", 32'(bus.rob_count), 5);
    #1;
    rst = 1'b0;
    #1;
    chk("t1_count", 32'(bus.rob_count), 0);
    chk("t1_alloc_tag", 32'(bus.alloc_tag), 1);
    chk("t1_wr_reg", 32'(bus.rf_wr_reg), 0);
    chk("t1_clear", 32'(bus.rf_clear), 0);
    #2;
    rst = 1'b1;
    cyc();

    // Query while the CDB is broadcasting the queried tag.
    alloc(5'd1);
    cyc();
    alloc(5'd2);
    cyc();
    bus.alloc_valid = 1'b0;
    cdb(4'd2, 32'h55);
    bus.query_tag1 = 4'd2;
    bus.query_tag2 = 4'd1;
    #1;
    chk("t6_byp_rdy", 32'(bus.query_rdy1), BYP ? 32'd1 : 32'd0);
    chk("t6_byp_val", bus.query_val1, BYP ? 32'h55 : 32'h0);
    chk("t6_q2_rdy", 32'(bus.query_rdy2), 0);
    cyc();
    bus.cdb_valid = 1'b0;
    #1;
    chk("t6_rdy", 32'(bus.query_rdy1), 1);
    chk("t6_val", bus.query_val1, 32'h55);
    chk("t6_q2_val", bus.query_val2, 0);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    cyc();

    // Fill to full. A commit in the same cycle as a rejected alloc leaves the tail at 1.
    for (int i = 0; i < 15; i++) begin
      alloc(5'(i + 1));
      cyc();
    end
    bus.alloc_valid = 1'b0;
    #1;
    chk("t3_count15", 32'(bus.rob_count), 15);
    chk("t3_full", 32'(bus.alloc_ready), 0);
    chk("t3_tail_wrap", 32'(bus.alloc_tag), 1);
    cdb(4'd1, 32'hAB);
    cyc();
    bus.cdb_valid = 1'b0;
    alloc(5'd20);
    #1;
    chk("t3_ready_commit", 32'(bus.alloc_ready), 0);
    chk("t3_occ_reject", 32'(bus.rf_occ_reg), 0);
    cyc();
    bus.alloc_valid = 1'b0;
    #1;
    chk("t3_wr_tag", 32'(bus.rf_wr_tag), 1);
    chk("t3_wr_reg", 32'(bus.rf_wr_reg), 1);
    chk("t3_wr_val", bus.rf_wr_value, 32'hAB);
    chk("t3_count14", 32'(bus.rob_count), 14);
    chk("t3_ready", 32'(bus.alloc_ready), 1);
    chk("t3_alloc_tag", 32'(bus.alloc_tag), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
